// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: SLL/SRL/SRA/ROL/ROR, STEP bit positions per clock,
// valid/ready on both operand and result sides.
module seq_shifter #(
   parameter int WIDTH = 16,
   parameter int STEP  = 1,
   localparam int AW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AW-1:0]    in_amt,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zero,
   output logic             out_illegal,
   output logic             busy
);

   // one extra bit so STEP == WIDTH is representable
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] STEP_C  = CW'(STEP);
   localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

   localparam logic [2:0] OP_SLL = 3'd0;
   localparam logic [2:0] OP_SRL = 3'd1;
   localparam logic [2:0] OP_SRA = 3'd2;
   localparam logic [2:0] OP_ROL = 3'd3;
   localparam logic [2:0] OP_ROR = 3'd4;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [AW-1:0]    amt;
      logic [2:0]       op;
   } req_t;

   state_t           state, state_nxt;
   req_t             req;
   logic [WIDTH-1:0] work, shifted;
   logic [AW-1:0]    rem;
   logic [2:0]       op;
   logic             illegal;
   logic             req_illegal;
   logic [CW-1:0]    rem_x, s;

   assign req         = '{data: in_data, amt: in_amt, op: in_op};
   assign req_illegal = (req.op > OP_ROR);

   assign rem_x = {1'b0, rem};
   assign s     = (rem_x < STEP_C) ? rem_x : STEP_C;

   // SRA keeps the sign: the MSB never changes under an arithmetic shift,
   // so every step refills with the captured operand's sign.
   always_comb begin
      shifted = work;
      case (op)
         OP_SLL:  shifted = work << s;
         OP_SRL:  shifted = work >> s;
         OP_SRA:  shifted = $signed(work) >>> s;
         OP_ROL:  shifted = (work << s) | (work >> (WIDTH_C - s));
         OP_ROR:  shifted = (work >> s) | (work << (WIDTH_C - s));
         default: shifted = work;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) begin
            if (req_illegal || req.amt == '0) state_nxt = DONE;
            else                              state_nxt = SHIFT;
         end
         SHIFT: if (rem_x == s) state_nxt = DONE;
         DONE:  if (out_ready)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         work    <= '0;
         rem     <= '0;
         op      <= '0;
         illegal <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (in_valid) begin
               work    <= req.data;
               rem     <= req.amt;
               op      <= req.op;
               illegal <= req_illegal;
            end
            SHIFT: begin
               work <= shifted;
               rem  <= rem - s[AW-1:0];
            end
            default: ;
         endcase
      end
   end

   assign in_ready    = (state == IDLE);
   assign out_valid   = (state == DONE);
   assign busy        = (state != IDLE);
   assign out_data    = work;
   assign out_zero    = (work == '0);
   assign out_illegal = illegal;

endmodule
